// File: rtl/ts_ci_bridge_if.sv
// Pin/handshake bundle for ts_ci_bridge: upstream TS byte stream, downstream
// FIFO write port, CI CAM input/output buses and the aligner status flags.
interface ts_ci_bridge_if;
  logic [7:0] in_d;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_d;
  logic       out_wrreq;
  logic       out_sop;
  logic       out_almost_full;
  logic [7:0] CI_MDI;
  logic       CI_MCLKI;
  logic       CI_MISTRT;
  logic       CI_MIVAL;
  logic [7:0] CI_MDO;
  logic       CI_MCLKO;
  logic       CI_MOSTRT;
  logic       CI_MOVAL;
  logic       in_locked;
  logic       sync_err;

  // bridge side
  modport slave (
    input  in_d, in_valid, out_almost_full, CI_MDO, CI_MCLKO, CI_MOSTRT, CI_MOVAL,
    output in_ready, out_d, out_wrreq, out_sop, CI_MDI, CI_MCLKI, CI_MISTRT, CI_MIVAL,
           in_locked, sync_err
  );

  // environment side (router FIFOs and CAM)
  modport master (
    output in_d, in_valid, out_almost_full, CI_MDO, CI_MCLKO, CI_MOSTRT, CI_MOVAL,
    input  in_ready, out_d, out_wrreq, out_sop, CI_MDI, CI_MCLKI, CI_MISTRT, CI_MIVAL,
           in_locked, sync_err
  );
endinterface

// File: rtl/ts_ci_bridge.sv
// CI TS bridge: packet-aligned TS byte launch onto the CAM input bus and capture of
// the asynchronous CAM output bus. Define TS_CI_BRIDGE_STATS_EN for packet counters.
module ts_ci_bridge #(
  parameter int         CLK_DIV   = 4,
  parameter int         PKT_LEN   = 188,
  parameter logic [7:0] SYNC_BYTE = 8'h47
) (
  input  logic          clk,
  input  logic          reset,
  ts_ci_bridge_if.slave bus
`ifdef TS_CI_BRIDGE_STATS_EN
  ,
  input  logic          stat_clr,
  output logic [31:0]   stat_in_pkts,
  output logic [31:0]   stat_out_pkts,
  output logic [31:0]   stat_drop_pkts,
  output logic [15:0]   stat_sync_err
`endif
);

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [7:0] PKT_LAST = 8'(PKT_LEN);

  typedef enum logic       {HUNT, LOCK} in_state_t;
  typedef enum logic [1:0] {OUT_HUNT, PASS, DROP} out_state_t;

  logic [3:0] div_cnt_r;
  logic       mclki_r;
  logic       launch_s;
  logic       take_s;
  logic       is_sync_s;
  logic       pkt_end_s;

  in_state_t  in_state_r;
  logic [7:0] byte_cnt_r;
  logic [7:0] mdi_r;
  logic       mival_r;
  logic       mistrt_r;
  logic       in_locked_r;
  logic       sync_err_r;

  logic [2:0] mclko_sync_r;
  logic [7:0] mdo_m1_r;
  logic [7:0] mdo_m2_r;
  logic [1:0] mostrt_sync_r;
  logic [1:0] moval_sync_r;
  logic       rise_s;
  logic       start_s;

  out_state_t out_state_r;
  logic [7:0] out_d_r;
  logic       out_wrreq_r;
  logic       out_sop_r;

  // Launch tick is the cycle whose closing edge drives CI_MCLKI from 1 to 0.
  assign launch_s  = (div_cnt_r == DIV_LAST) && mclki_r;
  assign take_s    = launch_s && bus.in_valid && !reset;
  assign is_sync_s = (bus.in_d == SYNC_BYTE);
  assign pkt_end_s = (byte_cnt_r == PKT_LAST);
  assign rise_s    = mclko_sync_r[1] && !mclko_sync_r[2];
  assign start_s   = rise_s && moval_sync_r[1] && mostrt_sync_r[1];

  assign bus.in_ready  = take_s;
  assign bus.CI_MDI    = mdi_r;
  assign bus.CI_MCLKI  = mclki_r;
  assign bus.CI_MISTRT = mistrt_r;
  assign bus.CI_MIVAL  = mival_r;
  assign bus.in_locked = in_locked_r;
  assign bus.sync_err  = sync_err_r;
  assign bus.out_d     = out_d_r;
  assign bus.out_wrreq = out_wrreq_r;
  assign bus.out_sop   = out_sop_r;

  // Free-running CAM input clock divider.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_r <= 4'd0;
      mclki_r   <= 1'b0;
    end else if (div_cnt_r == DIV_LAST) begin
      div_cnt_r <= 4'd0;
      mclki_r   <= ~mclki_r;
    end else begin
      div_cnt_r <= div_cnt_r + 4'd1;
    end
  end

  // Input aligner: CAM input bus only changes on launch ticks.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_state_r  <= HUNT;
      byte_cnt_r  <= 8'd0;
      mdi_r       <= 8'd0;
      mival_r     <= 1'b0;
      mistrt_r    <= 1'b0;
      in_locked_r <= 1'b0;
      sync_err_r  <= 1'b0;
    end else begin
      sync_err_r <= 1'b0;
      if (launch_s) begin
        if (!bus.in_valid) begin
          mival_r  <= 1'b0;
          mistrt_r <= 1'b0;
        end else begin
          case (in_state_r)
            HUNT: begin
              if (is_sync_s) begin
                mdi_r       <= bus.in_d;
                mival_r     <= 1'b1;
                mistrt_r    <= 1'b1;
                byte_cnt_r  <= 8'd1;
                in_state_r  <= LOCK;
                in_locked_r <= 1'b1;
              end else begin
                mival_r  <= 1'b0;
                mistrt_r <= 1'b0;
              end
            end
            LOCK: begin
              if (!pkt_end_s) begin
                mdi_r      <= bus.in_d;
                mival_r    <= 1'b1;
                mistrt_r   <= 1'b0;
                byte_cnt_r <= byte_cnt_r + 8'd1;
              end else if (is_sync_s) begin
                mdi_r      <= bus.in_d;
                mival_r    <= 1'b1;
                mistrt_r   <= 1'b1;
                byte_cnt_r <= 8'd1;
              end else begin
                mival_r     <= 1'b0;
                mistrt_r    <= 1'b0;
                sync_err_r  <= 1'b1;
                byte_cnt_r  <= 8'd0;
                in_state_r  <= HUNT;
                in_locked_r <= 1'b0;
              end
            end
            default: begin
              mival_r     <= 1'b0;
              mistrt_r    <= 1'b0;
              byte_cnt_r  <= 8'd0;
              in_state_r  <= HUNT;
              in_locked_r <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  // Two-flop synchronisers for the CAM output bus; clock gets a third stage for edge detect.
  always_ff @(posedge clk) begin
    if (reset) begin
      mclko_sync_r  <= 3'd0;
      mdo_m1_r      <= 8'd0;
      mdo_m2_r      <= 8'd0;
      mostrt_sync_r <= 2'd0;
      moval_sync_r  <= 2'd0;
    end else begin
      mclko_sync_r  <= {mclko_sync_r[1:0], bus.CI_MCLKO};
      mdo_m1_r      <= bus.CI_MDO;
      mdo_m2_r      <= mdo_m1_r;
      mostrt_sync_r <= {mostrt_sync_r[0], bus.CI_MOSTRT};
      moval_sync_r  <= {moval_sync_r[0], bus.CI_MOVAL};
    end
  end

  // Output capture: the go/drop decision is taken once per packet, at its start byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_state_r <= OUT_HUNT;
      out_d_r     <= 8'd0;
      out_wrreq_r <= 1'b0;
      out_sop_r   <= 1'b0;
    end else begin
      out_wrreq_r <= 1'b0;
      out_sop_r   <= 1'b0;
      if (start_s) begin
        if (bus.out_almost_full) begin
          out_state_r <= DROP;
        end else begin
          out_state_r <= PASS;
          out_d_r     <= mdo_m2_r;
          out_wrreq_r <= 1'b1;
          out_sop_r   <= 1'b1;
        end
      end else if (rise_s && moval_sync_r[1] && (out_state_r == PASS)) begin
        out_d_r     <= mdo_m2_r;
        out_wrreq_r <= 1'b1;
      end
    end
  end

`ifdef TS_CI_BRIDGE_STATS_EN
  logic        in_sop_s;
  logic        drop_s;
  logic [31:0] stat_in_r;
  logic [31:0] stat_out_r;
  logic [31:0] stat_drop_r;
  logic [15:0] stat_serr_r;

  assign in_sop_s       = take_s && is_sync_s && ((in_state_r == HUNT) || pkt_end_s);
  assign drop_s         = start_s && bus.out_almost_full;
  assign stat_in_pkts   = stat_in_r;
  assign stat_out_pkts  = stat_out_r;
  assign stat_drop_pkts = stat_drop_r;
  assign stat_sync_err  = stat_serr_r;

  // Wrapping event counters; clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (reset || stat_clr) begin
      stat_in_r   <= 32'd0;
      stat_out_r  <= 32'd0;
      stat_drop_r <= 32'd0;
      stat_serr_r <= 16'd0;
    end else begin
      stat_in_r   <= stat_in_r + {31'd0, in_sop_s};
      stat_out_r  <= stat_out_r + {31'd0, out_wrreq_r && out_sop_r};
      stat_drop_r <= stat_drop_r + {31'd0, drop_s};
      stat_serr_r <= stat_serr_r + {15'd0, sync_err_r};
    end
  end
`endif

endmodule

// File: doc/ts_ci_bridge.md
Name: ts_ci_bridge

Overview:
- Parametrised successor of the CI TS bridge: moves TS bytes from an upstream byte stream onto the CAM parallel input bus and captures the CAM parallel output bus into a downstream FIFO interface.
- Adds configurable bus clock divider, packet length and sync byte, plus packet-aligned sync lock on both directions.
- Adds whole-packet drop on output back-pressure.
- Sits between the TS router FIFOs and the CI connector pins.

Parameters:
CLK_DIV, 4, clk cycles per CI_MCLKI half-period (2..15)
PKT_LEN, 188, TS packet length in bytes (188 or 204; 8..255 legal)
SYNC_BYTE, 8'h47, packet sync byte

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
in_d  in  8  upstream TS byte
in_valid  in  1  in_d valid
in_ready  out  1  one-cycle pop strobe; byte consumed when in_valid&in_ready
out_d  out  8  captured CAM byte
out_wrreq  out  1  one-cycle write strobe for out_d
out_sop  out  1  qualifies out_wrreq; byte is packet start
out_almost_full  in  1  downstream back-pressure
CI_MDI  out  8  CAM input data
CI_MCLKI  out  1  CAM input clock
CI_MISTRT  out  1  CAM input packet start
CI_MIVAL  out  1  CAM input byte valid
CI_MDO  in  8  CAM output data (async to clk)
CI_MCLKO  in  1  CAM output clock (async)
CI_MOSTRT  in  1  CAM output packet start
CI_MOVAL  in  1  CAM output byte valid
in_locked  out  1  input aligner in LOCK
sync_err  out  1  one-cycle pulse on input sync loss

Behaviour:
- Reset: every output 0; divider 0; byte counter 0; input FSM HUNT; output FSM OUT_HUNT; sync flops 0. Reset mid-packet abandons the packet; no in_ready pulse while reset is high.
- Divider: 4-bit count 0..CLK_DIV-1. At terminal count, wraps to 0 and toggles CI_MCLKI, regardless of data availability. "Launch tick" = the cycle CI_MCLKI goes 1->0.
- Launch tick, in_valid=0: CI_MIVAL<=0, CI_MISTRT<=0, CI_MDI held, in_ready=0.
- Launch tick, in_valid=1: in_ready=1 for exactly that cycle; byte registered the same edge. CI_MDI/MIVAL/MISTRT change only on launch ticks, so they are stable across the CAM rising edge.
- Input FSM:
  - HUNT: byte != SYNC_BYTE is consumed and discarded (CI_MIVAL<=0). Byte == SYNC_BYTE is driven with CI_MISTRT=1 and CI_MIVAL=1; cnt<=1; go to LOCK.
  - LOCK: if cnt < PKT_LEN, drive byte with MIVAL=1, MISTRT=0; cnt++.
  - LOCK, cnt == PKT_LEN: byte == SYNC_BYTE -> MISTRT=1, cnt<=1. Otherwise discard the byte, MIVAL<=0, pulse sync_err, go to HUNT.
  - in_locked = (state == LOCK). Byte counter is 8-bit; never exceeds PKT_LEN.
- Output capture: CI_MCLKO, MDO, MOSTRT and MOVAL each pass through a 2-flop synchroniser. A rising edge is detected on the 2nd/3rd stage of CI_MCLKO; data is sampled from the 2nd stage on that edge. Latency from the synchronised edge to out_wrreq is 1 clk.
- Output FSM:
  - OUT_HUNT: ignore bytes until MOVAL&MOSTRT.
  - On any MOVAL&MOSTRT: if out_almost_full=1, go to DROP and write nothing. Otherwise go to PASS and write the byte with out_sop=1.
  - PASS: each MOVAL byte is written with out_sop=0.
  - DROP: discard until the next MOVAL&MOSTRT, which re-evaluates out_almost_full.
  - out_almost_full rising mid-packet does not cut the packet.
  - Bytes with MOVAL=0 are never written.
- Input and output paths run independently in the same cycle with no interaction.

Optional Feature:
- Macro TS_CI_BRIDGE_STATS_EN.
- Defined:
  - adds outputs stat_in_pkts[31:0], stat_out_pkts[31:0], stat_drop_pkts[31:0] and stat_sync_err[15:0], plus input stat_clr.
  - Counters increment on CI_MISTRT launch, out_sop write, DROP entry and sync_err respectively.
  - All counters wrap at max.
  - stat_clr (sync, 1 cycle) zeroes all counters and wins over a same-cycle increment; reset also zeroes them.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- CLK_DIV=4, in_valid held 1: CI_MCLKI period is 8 clk. One in_ready pulse per 8 clk. Data changes only on the falling edge.
- Stream 3 garbage bytes then 2 aligned 188-byte packets: garbage consumed with MIVAL=0. MISTRT high on byte 0 and byte 188. in_locked=1 after the first 0x47.
- Corrupt the sync byte of packet 2: that byte has MIVAL=0, sync_err pulses once, in_locked=0, and re-lock occurs on the next 0x47.
- PKT_LEN=204 build, 204-byte packets: MISTRT every 204 bytes and no sync_err.
- CAM drives 2 packets, out_almost_full=1 at packet 1's MOSTRT and 0 before packet 2: 0 writes for packet 1. 188 writes for packet 2 with out_sop on the first.
- Assert reset mid-packet: the next cycle shows all outputs 0. Afterwards the input returns to HUNT and the output ignores bytes until the next MOSTRT.
